color_mixer_arbiter: RTL and testbench

- Shares one 4-operand colour mixer between two pixel-pipeline requesters: r0 = texture-environment stage, r1 = blend/fog stage.
- The mixer computes (A*B)+(C*D) per sub-pixel, is saturated, and has fixed latency.
- The block arbitrates round-robin, drives the mixer operands and its clock enable, and tracks in-flight operations with their requester id and user tag.
- It returns each result on the owning requester's valid/ready output through a one-entry output register.

---
 rtl/pixel_pkg.sv | 28 ++
 rtl/rr_arbiter2.sv | 44 ++++
 rtl/color_mixer_arbiter.sv | 111 +++++++++++
 tb/tb_color_mixer_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// pixel_pkg: shared types and constants for the colour mixer arbiter.
// Holds the channel geometry, the pixel type, the four-operand mixer record
// and the record carried down the in-flight tracking pipe.
package pixel_pkg;

    localparam int SUB_PIXEL_WIDTH     = 8;
    localparam int NUMBER_OF_SUB_PIXEL = 4;
    localparam int PIXEL_WIDTH         = SUB_PIXEL_WIDTH * NUMBER_OF_SUB_PIXEL;
    localparam int USER_WIDTH          = 16;

    typedef logic [PIXEL_WIDTH-1:0] pixel_t;

    // Operand A sits in the least significant bits, matching the requester bus layout.
    typedef struct packed {
        pixel_t d;
        pixel_t c;
        pixel_t b;
        pixel_t a;
    } mix_op_t;

    // One slot of the tracking pipe: a bubble has valid = 0.
    typedef struct packed {
        logic                  valid;
        logic                  id;
        logic [USER_WIDTH-1:0] user;
    } track_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter.
// Ports:
//   aclk, reset     clock and asynchronous active-high reset
//   i_req[1:0]      request per requester
//   i_accept        the current grant was actually taken this cycle
//   o_grant_valid   some requester is granted
//   o_grant_id      index of the granted requester
module rr_arbiter2 (
    input  logic       aclk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic       o_grant_valid,
    output logic       o_grant_id
);

    // Remembers the last requester that completed a transfer. Resetting it to 1
    // makes requester 0 the preferred one after reset.
    logic r_last_id;

    // A lone requester always wins; under contention the one that did not win
    // last time gets the grant.
    always_comb begin
        o_grant_valid = |i_req;
        o_grant_id    = 1'b0;
        case (i_req)
            2'b01:   o_grant_id = 1'b0;
            2'b10:   o_grant_id = 1'b1;
            2'b11:   o_grant_id = ~r_last_id;
            default: o_grant_id = 1'b0;
        endcase
    end

    // The pointer only moves when the grant turns into a real transfer, so a
    // stalled grant keeps its priority.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            r_last_id <= 1'b1;
        end else if (i_accept) begin
            r_last_id <= o_grant_id;
        end
    end

endmodule

// File: rtl/color_mixer_arbiter.sv
// color_mixer_arbiter: shares one external (A*B)+(C*D) colour mixer between
// two requesters, tracks in-flight operations and returns each result to its
// owner through a one-entry output register.
// Ports:
//   aclk, reset            clock and asynchronous active-high reset
//   s_valid/s_ready[1:0]   per-requester operation handshake
//   s_colors               per requester {D,C,B,A}, requester 0 in the LSBs
//   s_user                 per-requester sideband tag
//   m_valid/m_ready[1:0]   per-requester result handshake
//   m_color, m_user        shared result colour and tag
//   mix_ce                 mixer clock enable
//   mix_color_a..d         mixer operands
//   mix_result             registered mixer output
module color_mixer_arbiter
    import pixel_pkg::*;
#(
    parameter int MIX_LATENCY = 2
) (
    input  logic                       aclk,
    input  logic                       reset,
    input  logic [1:0]                 s_valid,
    output logic [1:0]                 s_ready,
    input  logic [2*4*PIXEL_WIDTH-1:0] s_colors,
    input  logic [2*USER_WIDTH-1:0]    s_user,
    output logic [1:0]                 m_valid,
    input  logic [1:0]                 m_ready,
    output logic [PIXEL_WIDTH-1:0]     m_color,
    output logic [USER_WIDTH-1:0]      m_user,
    output logic                       mix_ce,
    output logic [PIXEL_WIDTH-1:0]     mix_color_a,
    output logic [PIXEL_WIDTH-1:0]     mix_color_b,
    output logic [PIXEL_WIDTH-1:0]     mix_color_c,
    output logic [PIXEL_WIDTH-1:0]     mix_color_d,
    input  logic [PIXEL_WIDTH-1:0]     mix_result
);

    localparam int OP_W = $bits(mix_op_t);

    mix_op_t               w_ops [2];
    logic [USER_WIDTH-1:0] w_user [2];
    mix_op_t               w_sel_op;
    logic                  w_grant_valid;
    logic                  w_grant_id;
    logic                  w_accept;
    logic                  w_mix_ce;

    track_t                r_pipe [1:MIX_LATENCY];
    track_t                r_out;
    pixel_t                r_out_color;

    assign w_ops[0]  = s_colors[0 +: OP_W];
    assign w_ops[1]  = s_colors[OP_W +: OP_W];
    assign w_user[0] = s_user[0 +: USER_WIDTH];
    assign w_user[1] = s_user[USER_WIDTH +: USER_WIDTH];

    // The whole pipe advances unless the output register holds a result its
    // owner is not taking. A stall on one requester therefore blocks both,
    // since they share a single pipe; a bubble at the output never stalls.
    assign w_mix_ce = !r_out.valid || m_ready[r_out.id];
    assign w_accept = w_mix_ce && w_grant_valid;
    assign mix_ce   = w_mix_ce;
    assign s_ready  = {w_accept && w_grant_id, w_accept && !w_grant_id};

    rr_arbiter2 u_arbiter (
        .aclk          (aclk),
        .reset         (reset),
        .i_req         (s_valid),
        .i_accept      (w_accept),
        .o_grant_valid (w_grant_valid),
        .o_grant_id    (w_grant_id)
    );

    // Operands follow the granted requester; with no grant the mixer sees zeros
    // and the matching tracking slot carries a bubble.
    always_comb begin
        w_sel_op = '0;
        if (w_grant_valid) begin
            w_sel_op = w_ops[w_grant_id];
        end
    end

    assign mix_color_a = w_sel_op.a;
    assign mix_color_b = w_sel_op.b;
    assign mix_color_c = w_sel_op.c;
    assign mix_color_d = w_sel_op.d;

    // Tracking pipe mirrors the mixer's depth so that the record leaving the
    // last stage lines up with mix_result; both land in the output register
    // together. Everything holds while the mixer clock enable is low.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            for (int k = 1; k <= MIX_LATENCY; k++) begin
                r_pipe[k] <= '0;
            end
            r_out       <= '0;
            r_out_color <= '0;
        end else if (w_mix_ce) begin
            r_pipe[1] <= '{valid: w_accept, id: w_grant_id, user: w_user[w_grant_id]};
            for (int k = 2; k <= MIX_LATENCY; k++) begin
                r_pipe[k] <= r_pipe[k-1];
            end
            r_out       <= r_pipe[MIX_LATENCY];
            r_out_color <= mix_result;
        end
    end

    assign m_valid = {r_out.valid && r_out.id, r_out.valid && !r_out.id};
    assign m_color = r_out_color;
    assign m_user  = r_out.user;

endmodule

// File: tb/tb_color_mixer_arbiter.sv
// tb_color_mixer_arbiter: scoreboard bench for color_mixer_arbiter, including
// a behavioural model of the external saturating mixer.
module tb_color_mixer_arbiter;

    localparam int LAT = 2;
    localparam int PW  = 32;
    localparam int UW  = 16;
    localparam int OPW = 4 * PW;

    logic           aclk;
    logic           reset;
    logic [1:0]     s_valid;
    logic [1:0]     s_ready;
    logic [2*OPW-1:0] s_colors;
    logic [2*UW-1:0]  s_user;
    logic [1:0]     m_valid;
    logic [1:0]     m_ready;
    logic [PW-1:0]  m_color;
    logic [UW-1:0]  m_user;
    logic           mix_ce;
    logic [PW-1:0]  mix_color_a;
    logic [PW-1:0]  mix_color_b;
    logic [PW-1:0]  mix_color_c;
    logic [PW-1:0]  mix_color_d;
    logic [PW-1:0]  mix_result;

    typedef struct {
        logic          id;
        logic [UW-1:0] user;
        logic [PW-1:0] color;
    } exp_t;

    exp_t expQ [$];
    logic modelLast;
    int   nCompares;
    int   nMiscompares;

    color_mixer_arbiter #(.MIX_LATENCY(LAT)) dut (
        .aclk        (aclk),
        .reset       (reset),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_colors    (s_colors),
        .s_user      (s_user),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_color     (m_color),
        .m_user      (m_user),
        .mix_ce      (mix_ce),
        .mix_color_a (mix_color_a),
        .mix_color_b (mix_color_b),
        .mix_color_c (mix_color_c),
        .mix_color_d (mix_color_d),
        .mix_result  (mix_result)
    );

    // Free-running 10 ns clock.
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Reference arithmetic: per channel sat(((A*B)+(C*D)+255)>>8).
    function automatic logic [PW-1:0] mixRef(input logic [OPW-1:0] ops);
        logic [PW-1:0] res;
        int a, b, c, d, s;
        res = '0;
        for (int ch = 0; ch < 4; ch++) begin
            a = int'(ops[ch*8 +: 8]);
            b = int'(ops[PW + ch*8 +: 8]);
            c = int'(ops[2*PW + ch*8 +: 8]);
            d = int'(ops[3*PW + ch*8 +: 8]);
            s = (a*b + c*d + 255) >> 8;
            res[ch*8 +: 8] = (s > 255) ? 8'hFF : s[7:0];
        end
        return res;
    endfunction

    // External mixer model: LAT clock-enabled stages with a registered output.
    logic [PW-1:0] mixPipe [LAT];
    always @(posedge aclk) begin
        if (mix_ce) begin
            mixPipe[0] <= mixRef({mix_color_d, mix_color_c, mix_color_b, mix_color_a});
            for (int k = 1; k < LAT; k++) begin
                mixPipe[k] <= mixPipe[k-1];
            end
        end
    end
    assign mix_result = mixPipe[LAT-1];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompares++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] sv, input logic [OPW-1:0] op0, input logic [OPW-1:0] op1,
                                 input logic [UW-1:0] u0, input logic [UW-1:0] u1);
        s_valid  = sv;
        s_colors = {op1, op0};
        s_user   = {u1, u0};
    endtask

    function automatic logic [OPW-1:0] randOps();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic randStimulus(input logic [1:0] sv);
        applyStimulus(sv, randOps(), randOps(), UW'($urandom), UW'($urandom));
    endtask

    // Accept-side model: decides from the arbitration rules which requester
    // should be taken this cycle and, when one is, queues its expected result.
    always @(negedge aclk) begin : acceptModel
        logic       expCe;
        logic       expId;
        logic       expAcc;
        logic [1:0] expReady;
        exp_t       e;
        if (reset) begin
            expQ.delete();
            modelLast = 1'b1;
        end else begin
            expCe = !(|m_valid) || (|(m_valid & m_ready));
            checkOutput("mix_ce", 64'(mix_ce), 64'(expCe));
            expId    = (s_valid == 2'b11) ? ~modelLast : s_valid[1];
            expAcc   = expCe && (|s_valid);
            expReady = expAcc ? (expId ? 2'b10 : 2'b01) : 2'b00;
            checkOutput("s_ready", 64'(s_ready), 64'(expReady));
            if (expAcc) begin
                modelLast = expId;
                e.id      = expId;
                e.user    = s_user[expId*UW +: UW];
                e.color   = mixRef(s_colors[expId*OPW +: OPW]);
                expQ.push_back(e);
            end
        end
    end

    // Result monitor: every completed output handshake must match the oldest
    // outstanding operation, which enforces order, ownership and no duplicates.
    always @(negedge aclk) begin : resultMonitor
        exp_t e;
        if (reset) begin
            checkOutput("m_valid_in_reset", 64'(m_valid), 64'd0);
        end else if (|(m_valid & m_ready)) begin
            if (expQ.size() == 0) begin
                nCompares++;
                nMiscompares++;
                $display("[TB] FAIL unexpected_result: got m_valid=%b user=%0h expected no result", m_valid, m_user);
            end else begin
                e = expQ.pop_front();
                checkOutput("result", {14'd0, m_valid, m_user, m_color},
                            {14'd0, (e.id ? 2'b10 : 2'b01), e.user, e.color});
            end
        end
    end

    task automatic waitResult(output int lat);
        lat = -1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge aclk);
            if (|m_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic waitDrain();
        for (int n = 0; n < 60; n++) begin
            @(negedge aclk);
            if (expQ.size() == 0) break;
        end
        checkOutput("drain_empty", 64'(expQ.size()), 64'd0);
    endtask

    // Safety net in case something upstream never completes.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios followed by random stress.
    initial begin
        int            lat;
        logic [PW-1:0] heldColor;
        nCompares    = 0;
        nMiscompares = 0;
        modelLast    = 1'b1;
        reset        = 1'b1;
        m_ready      = 2'b11;
        applyStimulus(2'b00, '0, '0, '0, '0);
        @(negedge aclk);
        checkOutput("reset_m_valid", 64'(m_valid), 64'd0);
        checkOutput("reset_m_color", 64'(m_color), 64'd0);
        checkOutput("reset_m_user", 64'(m_user), 64'd0);
        @(posedge aclk); #1 reset = 1'b0;

        // Single op from r0.
        @(posedge aclk); #1;
        applyStimulus(2'b01, {32'h0, 32'h0, 32'h80808080, 32'hFFFFFFFF}, '0, 16'h0011, 16'h0);
        @(negedge aclk);
        checkOutput("t1_accept", 64'(s_ready), 64'b01);
        @(posedge aclk); #1 s_valid = 2'b00;
        waitResult(lat);
        checkOutput("t1_latency", 64'(lat), 64'd3);
        checkOutput("t1_m_valid", 64'(m_valid), 64'b01);
        checkOutput("t1_m_color", 64'(m_color), 64'h80808080);
        checkOutput("t1_m_user", 64'(m_user), 64'h0011);

        // Saturation on r1.
        @(posedge aclk); #1;
        applyStimulus(2'b10, '0, {4{32'hFFFFFFFF}}, 16'h0, 16'h0022);
        @(negedge aclk);
        checkOutput("t2_accept", 64'(s_ready), 64'b10);
        @(posedge aclk); #1 s_valid = 2'b00;
        waitResult(lat);
        checkOutput("t2_latency", 64'(lat), 64'd3);
        checkOutput("t2_m_valid", 64'(m_valid), 64'b10);
        checkOutput("t2_m_color", 64'(m_color), 64'hFFFFFFFF);
        waitDrain();

        // Contention straight after reset: strict alternation starting at r0.
        @(posedge aclk); #1 reset = 1'b1;
        @(posedge aclk); #1 reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge aclk); #1 randStimulus(2'b11);
            @(negedge aclk);
            checkOutput("contention_grant", 64'(s_ready), (i % 2 == 1) ? 64'b10 : 64'b01);
        end
        @(posedge aclk); #1 s_valid = 2'b00;
        waitDrain();

        // Backpressure on r0 with both requesters pushing.
        @(posedge aclk); #1 m_ready = 2'b10; randStimulus(2'b01);
        lat = -1;
        for (int n = 0; n < 20; n++) begin
            @(posedge aclk); #1 randStimulus(2'b11);
            @(negedge aclk);
            if (m_valid[0]) begin
                lat = n;
                break;
            end
        end
        checkOutput("bp_reached", 64'(lat >= 0), 64'd1);
        heldColor = m_color;
        for (int n = 0; n < 5; n++) begin
            @(posedge aclk); #1 randStimulus(2'b11);
            @(negedge aclk);
            checkOutput("bp_s_ready", 64'(s_ready), 64'b00);
            checkOutput("bp_mix_ce", 64'(mix_ce), 64'd0);
            checkOutput("bp_held", {30'd0, m_valid, m_color}, {30'd0, 2'b01, heldColor});
        end
        @(posedge aclk); #1 m_ready = 2'b11; s_valid = 2'b00;
        waitDrain();

        // Reset with operations in flight.
        for (int n = 0; n < 3; n++) begin
            @(posedge aclk); #1 randStimulus(2'b11);
        end
        @(posedge aclk); #1 reset = 1'b1; s_valid = 2'b00;
        @(negedge aclk);
        checkOutput("rst_flight_m_valid", 64'(m_valid), 64'd0);
        @(posedge aclk); #1 reset = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge aclk);
            checkOutput("post_rst_m_valid", 64'(m_valid), 64'd0);
        end
        @(posedge aclk); #1 randStimulus(2'b11);
        @(negedge aclk);
        checkOutput("post_rst_grant", 64'(s_ready), 64'b01);
        @(posedge aclk); #1 s_valid = 2'b00;
        waitDrain();

        // Random stress.
        for (int n = 0; n < 10000; n++) begin
            @(posedge aclk); #1;
            randStimulus(2'($urandom_range(0, 3)));
            m_ready = {($urandom % 4) != 0, ($urandom % 4) != 0};
        end
        @(posedge aclk); #1 s_valid = 2'b00; m_ready = 2'b11;
        waitDrain();

        $display("== %0d vectors applied, %0d miscompares ==", nCompares, nMiscompares);
        $finish;
    end

endmodule
